// File: rtl/dmem_axi_lite_ram_pkg.sv
// rtl/dmem_axi_lite_ram_pkg.sv - shared AXI response codes and write-FSM states
package dmem_axi_lite_ram_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_COLLECT,
        W_RESP
    } w_state_e;

endpackage

// File: rtl/dmem_axi_lite_ram_if.sv
// rtl/dmem_axi_lite_ram_if.sv - AXI4-Lite data-memory bus with master/slave views
interface dmem_axi_lite_ram_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] s_axi_awaddr;
    logic [2:0]            s_axi_awprot;
    logic                  s_axi_awvalid;
    logic                  s_axi_awready;
    logic [31:0]           s_axi_wdata;
    logic [3:0]            s_axi_wstrb;
    logic                  s_axi_wvalid;
    logic                  s_axi_wready;
    logic [1:0]            s_axi_bresp;
    logic                  s_axi_bvalid;
    logic                  s_axi_bready;
    logic [ADDR_WIDTH-1:0] s_axi_araddr;
    logic [2:0]            s_axi_arprot;
    logic                  s_axi_arvalid;
    logic                  s_axi_arready;
    logic [31:0]           s_axi_rdata;
    logic [1:0]            s_axi_rresp;
    logic                  s_axi_rvalid;
    logic                  s_axi_rready;

    modport slave (
        input  s_axi_awaddr, s_axi_awprot, s_axi_awvalid,
        output s_axi_awready,
        input  s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
        output s_axi_wready,
        output s_axi_bresp, s_axi_bvalid,
        input  s_axi_bready,
        input  s_axi_araddr, s_axi_arprot, s_axi_arvalid,
        output s_axi_arready,
        output s_axi_rdata, s_axi_rresp, s_axi_rvalid,
        input  s_axi_rready
    );

    modport master (
        output s_axi_awaddr, s_axi_awprot, s_axi_awvalid,
        input  s_axi_awready,
        output s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
        input  s_axi_wready,
        input  s_axi_bresp, s_axi_bvalid,
        output s_axi_bready,
        output s_axi_araddr, s_axi_arprot, s_axi_arvalid,
        input  s_axi_arready,
        input  s_axi_rdata, s_axi_rresp, s_axi_rvalid,
        output s_axi_rready
    );
endinterface

// File: rtl/dmem_axi_lite_ram_byte_en_ram.sv
// rtl/dmem_axi_lite_ram_byte_en_ram.sv - DEPTHx32 RAM, sync read, byte-enabled write, read-first
module byte_en_ram #(
    parameter int DEPTH  = 1024,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] waddr,
    input  logic [31:0]      wdata,
    input  logic             re,
    input  logic [IDX_W-1:0] raddr,
    output logic [31:0]      rdata
);
    logic [31:0] mem [DEPTH];

    // Non-blocking read and write in one process gives old data on a same-word collision.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
        for (int i = 0; i < 4; i++) begin
            if (we && be[i]) begin
                mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end
endmodule

// File: rtl/dmem_axi_lite_ram.sv
// rtl/dmem_axi_lite_ram.sv - AXI4-Lite responder over an on-chip byte-enabled data RAM
module dmem_axi_lite_ram
    import dmem_axi_lite_ram_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DEPTH      = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic               clk,
    input  logic               reset,
    dmem_axi_lite_ram_if.slave axi
);
    localparam int                    IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] SPAN  = ADDR_WIDTH'(DEPTH * 4);

    w_state_e              state_q, state_d;
    logic                  aw_full, w_full;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [31:0]           w_data_q;
    logic [3:0]            w_strb_q;
    logic [1:0]            bresp_q, bresp_d;

    logic                  aw_hs, w_hs, commit;
    logic [ADDR_WIDTH-1:0] wr_addr, wr_offset, rd_offset;
    logic [31:0]           wr_data;
    logic [3:0]            wr_strb;
    logic                  wr_in_range, rd_in_range;

    logic                  ar_hs;
    logic                  rvalid_q, r_ok_q;
    logic [1:0]            rresp_q;
    logic [31:0]           ram_rdata;

    assign axi.s_axi_awready = (state_q == W_COLLECT) && !aw_full;
    assign axi.s_axi_wready  = (state_q == W_COLLECT) && !w_full;
    assign axi.s_axi_bvalid  = (state_q == W_RESP);
    assign axi.s_axi_bresp   = bresp_q;

    assign aw_hs = axi.s_axi_awvalid && axi.s_axi_awready;
    assign w_hs  = axi.s_axi_wvalid  && axi.s_axi_wready;

    // A beat arriving this cycle bypasses its holding register so the commit is not delayed.
    assign wr_addr = aw_full ? aw_addr_q : axi.s_axi_awaddr;
    assign wr_data = w_full  ? w_data_q  : axi.s_axi_wdata;
    assign wr_strb = w_full  ? w_strb_q  : axi.s_axi_wstrb;
    assign commit  = (state_q == W_COLLECT) && (aw_full || aw_hs) && (w_full || w_hs);

    assign wr_offset   = wr_addr - BASE_ADDR;
    assign wr_in_range = (wr_offset < SPAN);
    assign rd_offset   = axi.s_axi_araddr - BASE_ADDR;
    assign rd_in_range = (rd_offset < SPAN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= W_COLLECT;
            bresp_q <= AXI_RESP_OKAY;
            aw_full <= 1'b0;
            w_full  <= 1'b0;
        end else begin
            state_q <= state_d;
            bresp_q <= bresp_d;
            if (commit) begin
                aw_full <= 1'b0;
                w_full  <= 1'b0;
            end else begin
                if (aw_hs) aw_full <= 1'b1;
                if (w_hs)  w_full  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (aw_hs) aw_addr_q <= axi.s_axi_awaddr;
        if (w_hs) begin
            w_data_q <= axi.s_axi_wdata;
            w_strb_q <= axi.s_axi_wstrb;
        end
    end

    always_comb begin
        state_d = state_q;
        bresp_d = bresp_q;
        case (state_q)
            W_COLLECT: begin
                if (commit) begin
                    state_d = W_RESP;
                    bresp_d = wr_in_range ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
                end
            end
            W_RESP: begin
                if (axi.s_axi_bready) state_d = W_COLLECT;
            end
            default: state_d = W_COLLECT;
        endcase
    end

    assign axi.s_axi_arready = !rvalid_q || axi.s_axi_rready;
    assign ar_hs             = axi.s_axi_arvalid && axi.s_axi_arready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rvalid_q <= 1'b0;
            rresp_q  <= AXI_RESP_OKAY;
            r_ok_q   <= 1'b0;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rresp_q  <= rd_in_range ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
            r_ok_q   <= rd_in_range;
        end else if (axi.s_axi_rready) begin
            rvalid_q <= 1'b0;
        end
    end

    // The RAM output register is not reset; r_ok_q masks it to zero after reset and on errors.
    assign axi.s_axi_rvalid = rvalid_q;
    assign axi.s_axi_rresp  = rresp_q;
    assign axi.s_axi_rdata  = r_ok_q ? ram_rdata : 32'h0;

    byte_en_ram #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk   (clk),
        .we    (commit && wr_in_range),
        .be    (wr_strb),
        .waddr (wr_offset[IDX_W+1:2]),
        .wdata (wr_data),
        .re    (ar_hs),
        .raddr (rd_offset[IDX_W+1:2]),
        .rdata (ram_rdata)
    );
endmodule

// File: tb/tb_dmem_axi_lite_ram.sv
// tb/tb_dmem_axi_lite_ram.sv - directed and randomized checks of dmem_axi_lite_ram against a memory model
module tb_dmem_axi_lite_ram;
    localparam int          DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam logic [31:0] SPAN  = 32'(DEPTH * 4);

    logic clk;
    logic reset;
    int   vectors;
    int   errors;
    logic [31:0] ref_mem [DEPTH];

    dmem_axi_lite_ram_if #(.ADDR_WIDTH(32)) bus ();

    dmem_axi_lite_ram #(
        .ADDR_WIDTH (32),
        .DEPTH      (DEPTH),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .axi   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit in_rng(input logic [31:0] addr);
        return (addr - BASE) < SPAN;
    endfunction

    function automatic int word_of(input logic [31:0] addr);
        return int'((addr - BASE) / 4);
    endfunction

    function automatic logic [31:0] expect_rd(input logic [31:0] addr);
        return in_rng(addr) ? ref_mem[word_of(addr)] : 32'h0;
    endfunction

    task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        if (in_rng(addr)) begin
            for (int i = 0; i < 4; i++) begin
                if (strb[i]) ref_mem[word_of(addr)][8*i +: 8] = data[8*i +: 8];
            end
        end
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int b_dly);
        bit aw_done = 0;
        bit w_done  = 0;
        bit aw_take, w_take;
        int cyc = 0;
        logic [1:0] exp_resp = in_rng(addr) ? 2'b00 : 2'b10;
        bus.s_axi_awaddr = addr;
        bus.s_axi_wdata  = data;
        bus.s_axi_wstrb  = strb;
        bus.s_axi_bready = 1'b0;
        while (!(aw_done && w_done) && cyc < 40) begin
            bus.s_axi_awvalid = !aw_done && (cyc >= aw_dly);
            bus.s_axi_wvalid  = !w_done && (cyc >= w_dly);
            check("b_early", 32'(bus.s_axi_bvalid), 0);
            aw_take = bus.s_axi_awvalid && bus.s_axi_awready;
            w_take  = bus.s_axi_wvalid && bus.s_axi_wready;
            tick();
            aw_done |= aw_take;
            w_done  |= w_take;
            cyc++;
        end
        bus.s_axi_awvalid = 1'b0;
        bus.s_axi_wvalid  = 1'b0;
        check("wr_handshakes_done", 32'(aw_done && w_done), 1);
        check("b_latency", 32'(bus.s_axi_bvalid), 1);
        check("bresp", 32'(bus.s_axi_bresp), 32'(exp_resp));
        model_write(addr, data, strb);
        for (int i = 0; i < b_dly; i++) begin
            tick();
            check("b_hold", 32'(bus.s_axi_bvalid), 1);
            check("b_hold_resp", 32'(bus.s_axi_bresp), 32'(exp_resp));
            check("aw_blocked", 32'({bus.s_axi_awready, bus.s_axi_wready}), 0);
        end
        bus.s_axi_bready = 1'b1;
        tick();
        bus.s_axi_bready = 1'b0;
        check("b_clear", 32'(bus.s_axi_bvalid), 0);
        check("aw_w_ready_again", 32'({bus.s_axi_awready, bus.s_axi_wready}), 3);
    endtask

    task automatic axi_read(input logic [31:0] addr, input int r_dly);
        logic [31:0] exp_data = expect_rd(addr);
        logic [1:0]  exp_resp = in_rng(addr) ? 2'b00 : 2'b10;
        bus.s_axi_araddr  = addr;
        bus.s_axi_arvalid = 1'b1;
        bus.s_axi_rready  = 1'b0;
        check("ar_ready", 32'(bus.s_axi_arready), 1);
        tick();
        bus.s_axi_arvalid = 1'b0;
        check("r_latency", 32'(bus.s_axi_rvalid), 1);
        check("rdata", bus.s_axi_rdata, exp_data);
        check("rresp", 32'(bus.s_axi_rresp), 32'(exp_resp));
        for (int i = 0; i < r_dly; i++) begin
            tick();
            check("r_hold_valid", 32'(bus.s_axi_rvalid), 1);
            check("r_hold_data", bus.s_axi_rdata, exp_data);
            check("ar_blocked", 32'(bus.s_axi_arready), 0);
        end
        bus.s_axi_rready = 1'b1;
        tick();
        bus.s_axi_rready = 1'b0;
        check("r_clear", 32'(bus.s_axi_rvalid), 0);
    endtask

    initial begin
        logic [31:0] a, d, old;
        vectors = 0;
        errors  = 0;
        reset = 1'b1;
        bus.s_axi_awaddr = '0; bus.s_axi_awprot = '0; bus.s_axi_awvalid = 1'b0;
        bus.s_axi_wdata = '0;  bus.s_axi_wstrb = '0;  bus.s_axi_wvalid = 1'b0;
        bus.s_axi_bready = 1'b0;
        bus.s_axi_araddr = '0; bus.s_axi_arprot = '0; bus.s_axi_arvalid = 1'b0;
        bus.s_axi_rready = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        check("rst_readies", 32'({bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_arready}), 7);
        check("rst_bvalid", 32'(bus.s_axi_bvalid), 0);
        check("rst_bresp", 32'(bus.s_axi_bresp), 0);
        check("rst_rvalid", 32'(bus.s_axi_rvalid), 0);
        check("rst_rresp", 32'(bus.s_axi_rresp), 0);
        check("rst_rdata", bus.s_axi_rdata, 0);

        for (int w = 0; w < 64; w++) axi_write(BASE + 32'(w * 4), $urandom, 4'hF, 0, 0, 0);

        axi_write(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
        axi_read(BASE + 32'h10, 0);

        axi_write(BASE + 32'h20, 32'h1122_3344, 4'hF, 0, 0, 0);
        axi_write(BASE + 32'h20, 32'h00AA_0000, 4'b0100, 3, 0, 1);
        check("split_merge_model", ref_mem[8], 32'h11AA_3344);
        axi_read(BASE + 32'h20, 0);

        old = ref_mem[0];
        axi_write(BASE + SPAN, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
        axi_write(BASE - 32'd4, 32'hFFFF_FFFF, 4'hF, 1, 0, 0);
        axi_read(BASE + SPAN, 0);
        axi_read(BASE - 32'd4, 1);
        axi_read(BASE, 0);
        check("oor_no_write", ref_mem[0], old);

        axi_read(BASE, 4);
        bus.s_axi_rready  = 1'b1;
        bus.s_axi_arvalid = 1'b1;
        bus.s_axi_araddr  = BASE + 32'h4;
        tick();
        check("b2b_v0", 32'(bus.s_axi_rvalid), 1);
        check("b2b_d0", bus.s_axi_rdata, ref_mem[1]);
        check("b2b_ar", 32'(bus.s_axi_arready), 1);
        bus.s_axi_araddr = BASE + 32'h8;
        tick();
        bus.s_axi_arvalid = 1'b0;
        check("b2b_v1", 32'(bus.s_axi_rvalid), 1);
        check("b2b_d1", bus.s_axi_rdata, ref_mem[2]);
        tick();
        bus.s_axi_rready = 1'b0;
        check("b2b_end", 32'(bus.s_axi_rvalid), 0);

        axi_write(BASE + 32'h30, 32'h1, 4'hF, 0, 0, 0);
        bus.s_axi_awaddr = BASE + 32'h30; bus.s_axi_wdata = 32'h2; bus.s_axi_wstrb = 4'hF;
        bus.s_axi_araddr = BASE + 32'h30;
        bus.s_axi_awvalid = 1'b1; bus.s_axi_wvalid = 1'b1; bus.s_axi_arvalid = 1'b1;
        tick();
        bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0; bus.s_axi_arvalid = 1'b0;
        check("coll_bvalid", 32'(bus.s_axi_bvalid), 1);
        check("coll_rvalid", 32'(bus.s_axi_rvalid), 1);
        check("coll_old_data", bus.s_axi_rdata, 32'h1);
        model_write(BASE + 32'h30, 32'h2, 4'hF);
        bus.s_axi_bready = 1'b1; bus.s_axi_rready = 1'b1;
        tick();
        bus.s_axi_bready = 1'b0; bus.s_axi_rready = 1'b0;
        axi_read(BASE + 32'h30, 0);

        a = BASE + 32'h40;
        d = $urandom;
        bus.s_axi_awaddr = a; bus.s_axi_wdata = d; bus.s_axi_wstrb = 4'hF;
        bus.s_axi_araddr = BASE + 32'h44;
        bus.s_axi_awvalid = 1'b1; bus.s_axi_wvalid = 1'b1; bus.s_axi_arvalid = 1'b1;
        tick();
        bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0; bus.s_axi_arvalid = 1'b0;
        model_write(a, d, 4'hF);
        check("pre_rst_bvalid", 32'(bus.s_axi_bvalid), 1);
        check("pre_rst_rvalid", 32'(bus.s_axi_rvalid), 1);
        reset = 1'b1;
        #1;
        check("async_rst_bvalid", 32'(bus.s_axi_bvalid), 0);
        check("async_rst_rvalid", 32'(bus.s_axi_rvalid), 0);
        tick();
        reset = 1'b0;
        tick();
        check("post_rst_readies", 32'({bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_arready}), 7);
        check("post_rst_rdata", bus.s_axi_rdata, 0);
        axi_read(a, 0);

        for (int n = 0; n < 80; n++) begin
            int w = $urandom_range(0, 63);
            a = BASE + 32'(w * 4);
            if ($urandom_range(0, 7) == 0) a = BASE + SPAN + 32'(w * 4);
            if ($urandom_range(0, 1) == 0)
                axi_write(a, $urandom, 4'($urandom_range(0, 15)),
                          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
            else
                axi_read(a, $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
